// File: rtl/ysyx_23060077_riscv_axi_sram_param.sv
// AXI4-Lite SRAM slave with byte strobes and per-transaction response latency.
// Word memory (no reset) behind independent read and write channel FSMs.
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   axi_aw_* / axi_w_* / axi_b_*   write address, write data, write response
//   axi_ar_* / axi_r_*             read address, read data/response
//   *_port_i                       protection bits, ignored
// Latency is MIN_DELAY (DELAY_MODE=0) or MIN_DELAY + (lfsr & DELAY_MASK);
// reads use the LFSR value, writes use it bit-reversed.
// Out-of-range accesses answer SLVERR and never touch memory.
//
// Write FSM  state  | meaning
//            W_IDLE | readies up, AW and W captured independently
//            W_WAIT | counting down, commit strobed bytes at zero
//            W_RESP | b_valid held until b_ready
// Read FSM   state  | meaning
//            R_IDLE | ar_ready up, waiting for address
//            R_WAIT | counting down, sample memory word at zero
//            R_DATA | r_valid/r_data held until r_ready
module ysyx_23060077_riscv_axi_sram_param #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    DELAY_MODE = 1,
  parameter int                    MIN_DELAY  = 0,
  parameter logic [7:0]            DELAY_MASK = 8'h0F,
  parameter logic [7:0]            LFSR_SEED  = 8'h01
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  output logic                      axi_aw_ready_o,
  input  logic                      axi_aw_valid_i,
  input  logic [2:0]                axi_aw_port_i,
  input  logic [ADDR_WIDTH-1:0]     axi_aw_addr_i,
  output logic                      axi_w_ready_o,
  input  logic                      axi_w_valid_i,
  input  logic [DATA_WIDTH/8-1:0]   axi_w_strb_i,
  input  logic [DATA_WIDTH-1:0]     axi_w_data_i,
  output logic [1:0]                axi_b_resp_o,
  output logic                      axi_b_valid_o,
  input  logic                      axi_b_ready_i,
  output logic                      axi_ar_ready_o,
  input  logic                      axi_ar_valid_i,
  input  logic [2:0]                axi_ar_port_i,
  input  logic [ADDR_WIDTH-1:0]     axi_ar_addr_i,
  input  logic                      axi_r_ready_i,
  output logic                      axi_r_valid_o,
  output logic [1:0]                axi_r_resp_o,
  output logic [DATA_WIDTH-1:0]     axi_r_data_o
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(STRB);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int CNTW = 16;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * STRB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  w_state_e wstate_q, wstate_d;
  r_state_e rstate_q, rstate_d;

  logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d, ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [1:0]            b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB-1:0]       w_strb_q, w_strb_d;
  logic [CNTW-1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [7:0]            lfsr_q, lfsr_d, lfsr_rev;
  logic [CNTW-1:0]       rd_delay, wr_delay;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_in_range, ar_in_range;
  logic [IDXW-1:0]       aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_prot;

  assign unused_prot = ^{axi_aw_port_i, axi_ar_port_i};

  // Readies are only ever high in the idle states.
  assign aw_hs = axi_aw_valid_i & aw_ready_q;
  assign w_hs  = axi_w_valid_i & w_ready_q;
  assign ar_hs = axi_ar_valid_i & ar_ready_q;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign aw_off      = aw_addr_q - BASE_ADDR;
  assign ar_off      = ar_addr_q - BASE_ADDR;
  assign aw_in_range = aw_off < MEM_BYTES;
  assign ar_in_range = ar_off < MEM_BYTES;
  assign aw_idx      = aw_off[OFFW +: IDXW];
  assign ar_idx      = ar_off[OFFW +: IDXW];
  assign rd_word     = mem[ar_idx];

  assign wr_commit = (wstate_q == W_WAIT) && (wcnt_q == '0) && aw_in_range;

  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < 8; i++) lfsr_rev[i] = lfsr_q[7-i];
  end

  assign rd_delay = (DELAY_MODE == 0) ? CNTW'(MIN_DELAY)
                                      : CNTW'(MIN_DELAY) + CNTW'(lfsr_q & DELAY_MASK);
  assign wr_delay = (DELAY_MODE == 0) ? CNTW'(MIN_DELAY)
                                      : CNTW'(MIN_DELAY) + CNTW'(lfsr_rev & DELAY_MASK);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) wstate_d = W_WAIT;
      W_WAIT:  if (wcnt_q == '0) wstate_d = W_RESP;
      W_RESP:  if (axi_b_ready_i) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_WAIT;
      R_WAIT:  if (rcnt_q == '0) rstate_d = R_DATA;
      R_DATA:  if (axi_r_ready_i) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) aw_addr_d = axi_aw_addr_i;
        if (w_hs) begin
          w_data_d = axi_w_data_i;
          w_strb_d = axi_w_strb_i;
        end
        aw_got_d   = aw_got_q | aw_hs;
        w_got_d    = w_got_q | w_hs;
        aw_ready_d = ~aw_got_d;
        w_ready_d  = ~w_got_d;
        if (aw_got_d && w_got_d) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b0;
          wcnt_d     = wr_delay;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          b_valid_d = 1'b1;
          b_resp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          wcnt_d = wcnt_q - CNTW'(1);
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) begin
          b_valid_d = 1'b0;
          b_resp_d  = RESP_OKAY;
        end
      end
      default: ;
    endcase

    case (rstate_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_hs) begin
          ar_addr_d  = axi_ar_addr_i;
          ar_ready_d = 1'b0;
          rcnt_d     = rd_delay;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          r_valid_d = 1'b1;
          r_resp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_data_d  = ar_in_range ? rd_word : '0;
        end else begin
          rcnt_d = rcnt_q - CNTW'(1);
        end
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          r_valid_d = 1'b0;
          r_resp_d  = RESP_OKAY;
          r_data_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Storage is not reset; a same-edge read sees the pre-commit word.
  always_ff @(posedge aclk) begin
    if (wr_commit) begin
      for (int b = 0; b < STRB; b++) begin
        if (w_strb_q[b]) mem[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_data_o   = r_data_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_sram_param.sv
// Bench: instance 0 has fixed zero delay, instance 1 has LFSR delay 1..8.
module tb_ysyx_23060077_riscv_axi_sram_param;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT_LO = 2;
  localparam int          LAT_HI = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic        aw_ready [2];
  logic        aw_valid [2];
  logic [31:0] aw_addr  [2];
  logic        w_ready  [2];
  logic        w_valid  [2];
  logic [3:0]  w_strb   [2];
  logic [31:0] w_data   [2];
  logic [1:0]  b_resp   [2];
  logic        b_valid  [2];
  logic        b_ready  [2];
  logic        ar_ready [2];
  logic        ar_valid [2];
  logic [31:0] ar_addr  [2];
  logic        r_ready  [2];
  logic        r_valid  [2];
  logic [1:0]  r_resp   [2];
  logic [31:0] r_data   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_23060077_riscv_axi_sram_param #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .BASE_ADDR(32'h8000_0000),
      .DELAY_MODE((g == 0) ? 0 : 1), .MIN_DELAY((g == 0) ? 0 : 1),
      .DELAY_MASK(8'h07), .LFSR_SEED(8'h5A)
    ) u_dut (
      .aclk(clk), .areset_n(rst_n[g]),
      .axi_aw_ready_o(aw_ready[g]), .axi_aw_valid_i(aw_valid[g]), .axi_aw_port_i(3'b000),
      .axi_aw_addr_i(aw_addr[g]),
      .axi_w_ready_o(w_ready[g]), .axi_w_valid_i(w_valid[g]), .axi_w_strb_i(w_strb[g]),
      .axi_w_data_i(w_data[g]),
      .axi_b_resp_o(b_resp[g]), .axi_b_valid_o(b_valid[g]), .axi_b_ready_i(b_ready[g]),
      .axi_ar_ready_o(ar_ready[g]), .axi_ar_valid_i(ar_valid[g]), .axi_ar_port_i(3'b000),
      .axi_ar_addr_i(ar_addr[g]),
      .axi_r_ready_i(r_ready[g]), .axi_r_valid_o(r_valid[g]), .axi_r_resp_o(r_resp[g]),
      .axi_r_data_o(r_data[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int val, input int lo, input int hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data,
                    input logic [3:0] s, input int w_lead, input int bdly,
                    output logic [1:0] resp, output int lat);
    int k;
    logic hs_aw, hs_w;
    @(negedge clk);
    aw_addr[d] = a; w_data[d] = data; w_strb[d] = s;
    if (w_lead > 0) begin
      w_valid[d] = 1'b1;
      k = 0;
      while (!w_ready[d] && k < 50) begin @(negedge clk); k++; end
      @(negedge clk);
      w_valid[d] = 1'b0;
      check("w_ready_drop", 64'(w_ready[d]), 64'd0);
      repeat (w_lead - 1) @(negedge clk);
      check("aw_ready_waiting", 64'(aw_ready[d]), 64'd1);
    end
    aw_valid[d] = 1'b1;
    if (w_lead == 0) w_valid[d] = 1'b1;
    k = 0;
    while ((aw_valid[d] || w_valid[d]) && k < 50) begin
      hs_aw = aw_valid[d] && aw_ready[d];
      hs_w  = w_valid[d] && w_ready[d];
      @(negedge clk);
      k++;
      if (hs_aw) aw_valid[d] = 1'b0;
      if (hs_w)  w_valid[d]  = 1'b0;
    end
    check("aw_w_handshake", 64'(aw_valid[d] | w_valid[d]), 64'd0);
    aw_valid[d] = 1'b0; w_valid[d] = 1'b0;
    lat = 0;
    while (!b_valid[d] && lat < 300) begin @(negedge clk); lat++; end
    resp = b_resp[d];
    repeat (bdly) begin
      @(negedge clk);
      check("b_valid_hold", 64'(b_valid[d]), 64'd1);
      check("b_resp_hold", 64'(b_resp[d]), 64'(resp));
    end
    b_ready[d] = 1'b1;
    @(negedge clk);
    b_ready[d] = 1'b0;
    check("b_valid_clear", 64'(b_valid[d]), 64'd0);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input int rdly,
                    output logic [31:0] data, output logic [1:0] resp, output int lat);
    int k;
    @(negedge clk);
    ar_addr[d] = a; ar_valid[d] = 1'b1;
    k = 0;
    while (!ar_ready[d] && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    ar_valid[d] = 1'b0;
    check("ar_ready_drop", 64'(ar_ready[d]), 64'd0);
    lat = 0;
    while (!r_valid[d] && lat < 300) begin @(negedge clk); lat++; end
    data = r_data[d]; resp = r_resp[d];
    repeat (rdly) begin
      @(negedge clk);
      check("r_valid_hold", 64'(r_valid[d]), 64'd1);
      check("r_data_hold", 64'(r_data[d]), 64'(data));
    end
    r_ready[d] = 1'b1;
    @(negedge clk);
    r_ready[d] = 1'b0;
    check("r_valid_clear", 64'(r_valid[d]), 64'd0);
  endtask

  task automatic check_outs_zero(input int d);
    check("rst_aw_ready", 64'(aw_ready[d]), 64'd0);
    check("rst_w_ready",  64'(w_ready[d]),  64'd0);
    check("rst_b_valid",  64'(b_valid[d]),  64'd0);
    check("rst_b_resp",   64'(b_resp[d]),   64'd0);
    check("rst_ar_ready", 64'(ar_ready[d]), 64'd0);
    check("rst_r_valid",  64'(r_valid[d]),  64'd0);
    check("rst_r_resp",   64'(r_resp[d]),   64'd0);
    check("rst_r_data",   64'(r_data[d]),   64'd0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] mdl [256];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data, a, wd;
    logic [3:0]  s;
    int          lat, k, idx, seen;

    tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'hFF22_FF44};
    tbl[5]  = '{1'b1, 32'h8000_0023, 32'hAABB_CCDD, 4'h0, 2'b00, 32'h0};
    tbl[6]  = '{1'b0, 32'h8000_0022, 32'h0,         4'h0, 2'b00, 32'hFF22_FF44};
    tbl[7]  = '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
    tbl[8]  = '{1'b1, 32'h8000_03FC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    tbl[9]  = '{1'b1, 32'h8000_0400, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    tbl[10] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 2'b10, 32'h0};
    tbl[11] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
    tbl[12] = '{1'b0, 32'h8000_0400, 32'h0,         4'h0, 2'b10, 32'h0};
    tbl[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
    tbl[14] = '{1'b0, 32'h8000_03FC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    tbl[15] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; aw_valid[d] = 1'b0; w_valid[d] = 1'b0; ar_valid[d] = 1'b0;
      b_ready[d] = 1'b0; r_ready[d] = 1'b0;
      aw_addr[d] = '0; ar_addr[d] = '0; w_data[d] = '0; w_strb[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check_outs_zero(d);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("aw_ready_after_rst", 64'(aw_ready[d]), 64'd1);
      check("w_ready_after_rst",  64'(w_ready[d]),  64'd1);
      check("ar_ready_after_rst", 64'(ar_ready[d]), 64'd1);
    end

    // Directed table on the fixed-latency instance.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) begin
        wr(0, tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, resp, lat);
        check($sformatf("tbl%0d_b_resp", i), 64'(resp), 64'(tbl[i].exp_resp));
        check($sformatf("tbl%0d_b_lat", i), 64'(lat), 64'd1);
      end else begin
        rd(0, tbl[i].addr, 0, data, resp, lat);
        check($sformatf("tbl%0d_r_resp", i), 64'(resp), 64'(tbl[i].exp_resp));
        check($sformatf("tbl%0d_r_data", i), 64'(data), 64'(tbl[i].exp_data));
        check($sformatf("tbl%0d_r_lat", i), 64'(lat), 64'd1);
      end
    end

    // W three cycles ahead of AW, response back-pressured for five cycles.
    wr(0, 32'h8000_0030, 32'h0A0B_0C0D, 4'hF, 3, 5, resp, lat);
    check("wfirst_b_resp", 64'(resp), 64'd0);
    check("wfirst_b_lat", 64'(lat), 64'd1);
    rd(0, 32'h8000_0030, 2, data, resp, lat);
    check("wfirst_r_data", 64'(data), 64'h0A0B_0C0D);

    // Read sample and write commit on the same edge: read returns old word.
    wr(0, 32'h8000_0040, 32'h1111_1111, 4'hF, 0, 0, resp, lat);
    k = 0;
    while (!(aw_ready[0] && w_ready[0] && ar_ready[0]) && k < 50) begin @(negedge clk); k++; end
    aw_addr[0] = 32'h8000_0040; w_data[0] = 32'h2222_2222; w_strb[0] = 4'hF;
    ar_addr[0] = 32'h8000_0040;
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; ar_valid[0] = 1'b1;
    @(negedge clk);
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0; ar_valid[0] = 1'b0;
    @(negedge clk);
    check("same_edge_r_valid", 64'(r_valid[0]), 64'd1);
    check("same_edge_b_valid", 64'(b_valid[0]), 64'd1);
    check("same_edge_old_data", 64'(r_data[0]), 64'h1111_1111);
    r_ready[0] = 1'b1; b_ready[0] = 1'b1;
    @(negedge clk);
    r_ready[0] = 1'b0; b_ready[0] = 1'b0;
    rd(0, 32'h8000_0040, 0, data, resp, lat);
    check("same_edge_new_data", 64'(data), 64'h2222_2222);

    // Random traffic on the LFSR-latency instance against a word scoreboard.
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      mdl[i] = wd;
      wr(1, BASE + 32'(i * 4), wd, 4'hF, 0, 0, resp, lat);
      check("init_b_resp", 64'(resp), 64'd0);
      check_rng("init_b_lat", lat, LAT_LO, LAT_HI);
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 15);
        wd = $urandom; s = 4'($urandom);
        wr(1, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), wd, s,
           $urandom_range(0, 2), $urandom_range(0, 2), resp, lat);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
        check("rnd_b_resp", 64'(resp), 64'd0);
        check_rng("rnd_b_lat", lat, LAT_LO, LAT_HI);
      end
      if ($urandom_range(0, 9) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFC : BASE + 32'h400 + 32'($urandom_range(0, 63) * 4);
        rd(1, a, $urandom_range(0, 2), data, resp, lat);
        check("rnd_oor_resp", 64'(resp), 64'd2);
        check("rnd_oor_data", 64'(data), 64'd0);
      end else begin
        idx = $urandom_range(0, 15);
        rd(1, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), $urandom_range(0, 2), data, resp, lat);
        check("rnd_r_resp", 64'(resp), 64'd0);
        check("rnd_r_data", 64'(data), 64'(mdl[idx]));
      end
      check_rng("rnd_r_lat", lat, LAT_LO, LAT_HI);
      if (lat >= 0 && lat < 32) seen = seen | (1 << lat);
    end
    check_rng("rnd_lat_spread", $countones(seen), 4, 8);

    // Reset with a read parked in R_DATA and a write in W_WAIT.
    k = 0;
    while (!(aw_ready[1] && w_ready[1] && ar_ready[1]) && k < 50) begin @(negedge clk); k++; end
    ar_addr[1] = BASE + 32'h0C; ar_valid[1] = 1'b1;
    @(negedge clk);
    ar_valid[1] = 1'b0;
    k = 0;
    while (!r_valid[1] && k < 50) begin @(negedge clk); k++; end
    check("mid_r_valid", 64'(r_valid[1]), 64'd1);
    aw_addr[1] = BASE + 32'h14; w_data[1] = 32'h5A5A_A5A5; w_strb[1] = 4'hF;
    aw_valid[1] = 1'b1; w_valid[1] = 1'b1;
    @(negedge clk);
    aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    check_outs_zero(1);
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b1;
    rd(1, BASE + 32'h14, 0, data, resp, lat);
    check("rst_word_unchanged", 64'(data), 64'(mdl[5]));
    check_rng("rst_rd_lat", lat, LAT_LO, LAT_HI);
    rd(1, BASE + 32'h0C, 0, data, resp, lat);
    check("rst_rd_other", 64'(data), 64'(mdl[3]));
    wr(1, BASE + 32'h14, 32'h600D_CAFE, 4'hF, 0, 0, resp, lat);
    check("rst_clean_b_resp", 64'(resp), 64'd0);
    rd(1, BASE + 32'h14, 0, data, resp, lat);
    check("rst_clean_data", 64'(data), 64'h600D_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
